// File: rtl/uart_tx_framed.sv
// Framed UART transmitter with an input FIFO: start bit, LSB-first data, optional parity, 1 or 2 stop bits.
// Parity support is compiled in only when UART_TX_FRAMED_PARITY_EN is defined.
module uart_tx_framed #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [DATA_WIDTH-1:0]           s_axis_tdata,
  input  logic                            s_axis_tvalid,
  output logic                            s_axis_tready,
  output logic                            txd,
  output logic                            busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level,
  input  logic [15:0]                     prescale,
  input  logic                            stop2,
  input  logic [1:0]                      parity_mode
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                  state_reg, state_next;
  logic [DATA_WIDTH-1:0]   mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr_reg, rd_ptr_reg;
  logic [LW-1:0]           level_reg;
  logic                    ready_en_reg;
  logic [DATA_WIDTH-1:0]   shift_reg;
  logic [18:0]             cnt_reg;
  logic [18:0]             period_reg;
  logic [6:0]              bit_cnt_reg;
  logic                    stop2_reg;
  logic                    txd_reg, txd_next;
  logic                    push, pop;
  logic                    bit_done;
  logic [15:0]             presc_eff;

`ifdef UART_TX_FRAMED_PARITY_EN
  logic                    par_en_reg;
  logic                    par_bit_reg;
`else
  logic                    unused_parity;
  assign unused_parity = ^parity_mode;
`endif

  // ready_en_reg holds tready low during reset and until the first edge after it
  assign s_axis_tready = ready_en_reg && (level_reg < LW'(FIFO_DEPTH));
  assign push          = s_axis_tvalid && s_axis_tready;
  assign fifo_level    = level_reg;
  assign busy          = (state_reg != IDLE) || (level_reg != '0);
  assign txd           = txd_reg;
  assign bit_done      = (cnt_reg == period_reg - 19'd1);
  assign presc_eff     = (prescale == 16'd0) ? 16'd1 : prescale;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    txd_next   = 1'b1;
    pop        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (level_reg != '0) begin
          pop        = 1'b1;
          state_next = START;
        end
      end
      START: begin
        txd_next = 1'b0;
        if (bit_done) state_next = DATA;
      end
      DATA: begin
        txd_next = shift_reg[0];
        if (bit_done && (bit_cnt_reg == 7'(DATA_WIDTH-1))) begin
`ifdef UART_TX_FRAMED_PARITY_EN
          state_next = par_en_reg ? PARITY : STOP;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_TX_FRAMED_PARITY_EN
      PARITY: begin
        txd_next = par_bit_reg;
        if (bit_done) state_next = STOP;
      end
`endif
      STOP: begin
        // Chain straight into the next frame when a word is waiting
        if (bit_done && (bit_cnt_reg == {6'd0, stop2_reg})) begin
          if (level_reg != '0) begin
            pop        = 1'b1;
            state_next = START;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txd_reg      <= 1'b1;
      ready_en_reg <= 1'b0;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      level_reg    <= '0;
      shift_reg    <= '0;
      cnt_reg      <= '0;
      period_reg   <= 19'd8;
      bit_cnt_reg  <= '0;
      stop2_reg    <= 1'b0;
`ifdef UART_TX_FRAMED_PARITY_EN
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
`endif
    end else begin
      ready_en_reg <= 1'b1;
      txd_reg      <= txd_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + LW'(1);
        2'b01:   level_reg <= level_reg - LW'(1);
        default: level_reg <= level_reg;
      endcase
      if (pop) begin
        // Line settings are frozen per frame at the moment its word leaves the FIFO
        shift_reg   <= mem[rd_ptr_reg];
        period_reg  <= {presc_eff, 3'b000};
        stop2_reg   <= stop2;
        cnt_reg     <= '0;
        bit_cnt_reg <= '0;
`ifdef UART_TX_FRAMED_PARITY_EN
        par_en_reg  <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        par_bit_reg <= (^mem[rd_ptr_reg]) ^ (parity_mode == 2'b10);
`endif
      end else if (state_reg != IDLE) begin
        if (bit_done) begin
          cnt_reg <= '0;
          if (state_next != state_reg) bit_cnt_reg <= '0;
          else                         bit_cnt_reg <= bit_cnt_reg + 7'd1;
          if (state_reg == DATA) shift_reg <= shift_reg >> 1;
        end else begin
          cnt_reg <= cnt_reg + 19'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Scoreboard bench for uart_tx_framed: an 8-bit/depth-4 instance and a 64-bit/depth-2 instance.
// Expected frames are queued at stimulus time; per-instance monitors check the txd waveform cycle by cycle.
module tb_uart_tx_framed;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] prescale = 16'd2;
  logic        stop2 = 1'b0;
  logic [1:0]  parity_mode = 2'b00;

  logic [7:0]  tdata8 = '0;
  logic        tvalid8 = 1'b0;
  logic        tready8, txd8, busy8;
  logic [2:0]  level8;
  logic [63:0] tdata64 = '0;
  logic        tvalid64 = 1'b0;
  logic        tready64, txd64, busy64;
  logic [1:0]  level64;

  always #5 clk = ~clk;

  uart_tx_framed #(.DATA_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata8), .s_axis_tvalid(tvalid8),
    .s_axis_tready(tready8), .txd(txd8), .busy(busy8), .fifo_level(level8),
    .prescale(prescale), .stop2(stop2), .parity_mode(parity_mode));

  uart_tx_framed #(.DATA_WIDTH(64), .FIFO_DEPTH(2)) dut64 (
    .clk(clk), .rst(rst), .s_axis_tdata(tdata64), .s_axis_tvalid(tvalid64),
    .s_axis_tready(tready64), .txd(txd64), .busy(busy64), .fifo_level(level64),
    .prescale(prescale), .stop2(stop2), .parity_mode(parity_mode));

  typedef struct {
    logic [79:0] bits;
    int          nbits;
    int          t;
    logic [63:0] word;
  } frame_t;

  frame_t exp8[$];
  frame_t exp64[$];
  longint st8[$];
  longint st64[$];
  int     done_cnt[2];
  int     start_cnt[2];
  int     checks = 0;
  int     errors = 0;
  int     peak8 = 0;

  // Reference frame: start 0, data LSB first, optional parity, one or two stop bits, each T = 8*max(p,1)
  function automatic frame_t make_frame(input logic [63:0] d, input int dw, input int p,
                                        input bit s2, input logic [1:0] pm);
    frame_t f;
    int     n;
    logic   par;
    bit     par_on;
    n = 0;
    par = 1'b0;
    par_on = 1'b0;
    f.word = d;
    f.bits = '0;
    f.t = 8 * ((p == 0) ? 1 : p);
    f.bits[n] = 1'b0; n++;
    for (int i = 0; i < dw; i++) begin
      f.bits[n] = d[i];
      par ^= d[i];
      n++;
    end
    par = par ^ (pm == 2'b10);
`ifdef UART_TX_FRAMED_PARITY_EN
    par_on = (pm == 2'b01) || (pm == 2'b10);
`endif
    if (par_on) begin f.bits[n] = par; n++; end
    f.bits[n] = 1'b1; n++;
    if (s2) begin f.bits[n] = 1'b1; n++; end
    f.nbits = n;
    return f;
  endfunction

  function automatic int exp_count(input int which);
    return (which == 0) ? exp8.size() : exp64.size();
  endfunction

  function automatic frame_t pop_exp(input int which);
    if (which == 0) return exp8.pop_front();
    return exp64.pop_front();
  endfunction

  function automatic void push_exp(input int which, input frame_t f);
    if (which == 0) exp8.push_back(f);
    else            exp64.push_back(f);
  endfunction

  function automatic int start_count(input int which);
    return (which == 0) ? st8.size() : st64.size();
  endfunction

  function automatic longint pop_start(input int which);
    if (which == 0) return st8.pop_front();
    return st64.pop_front();
  endfunction

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d required %0d", name, act, req);
    end
  endtask

  task automatic monitor(input int which);
    frame_t f;
    int     cyc = 0;
    bit     active = 1'b0;
    bit     ok = 1'b1;
    bit     stray = 1'b0;
    int     bad_cyc = 0;
    logic   bad_val = 1'b0;
    logic   line;
    forever begin
      @(negedge clk);
      line = (which == 0) ? txd8 : txd64;
      if (rst) begin
        active = 1'b0;
        stray = 1'b0;
      end else if (stray) begin
        if (line) stray = 1'b0;
      end else begin
        if (!active && !line) begin
          if (exp_count(which) == 0) begin
            checks++; errors++;
            $display("FAIL stray_start dut%0d txd actual 0 required 1", which);
            stray = 1'b1;
          end else begin
            f = pop_exp(which);
            active = 1'b1; cyc = 0; ok = 1'b1;
            if (which == 0) st8.push_back(longint'($time) - 5);
            else            st64.push_back(longint'($time) - 5);
            start_cnt[which]++;
          end
        end
        if (active) begin
          if (line !== f.bits[cyc / f.t] && ok) begin
            ok = 1'b0; bad_cyc = cyc; bad_val = line;
          end
          cyc++;
          if (cyc == f.nbits * f.t) begin
            checks++;
            if (!ok) begin
              errors++;
              $display("FAIL frame dut%0d word %h cycle %0d txd actual %b required %b",
                       which, f.word, bad_cyc, bad_val, f.bits[bad_cyc / f.t]);
            end
            active = 1'b0;
            done_cnt[which]++;
          end
        end
      end
    end
  endtask

  initial monitor(0);
  initial monitor(1);

  initial forever begin
    @(negedge clk);
    if (int'(level8) > peak8) peak8 = int'(level8);
  end

  initial begin
    #3000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Called at a negedge; returns at the negedge after the accepting edge with tvalid dropped
  task automatic send(input int which, input logic [63:0] d, output longint acc_t);
    int guard;
    guard = 0;
    if (which == 0) begin tdata8 = d[7:0]; tvalid8 = 1'b1; end
    else            begin tdata64 = d;     tvalid64 = 1'b1; end
    while (((which == 0) ? tready8 : tready64) == 1'b0 && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 5000) begin
      checks++; errors++;
      $display("FAIL send_timeout dut%0d tready actual 0 required 1", which);
    end
    @(posedge clk);
    acc_t = longint'($time);
    @(negedge clk);
    tvalid8 = 1'b0;
    tvalid64 = 1'b0;
  endtask

  task automatic wait_done(input int which, input int target);
    int guard;
    guard = 0;
    while (done_cnt[which] < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (done_cnt[which] < target) begin
      checks++; errors++;
      $display("FAIL frames_done dut%0d actual %0d required %0d", which, done_cnt[which], target);
    end
  endtask

  task automatic wait_start(input int which, input int target);
    int guard;
    guard = 0;
    while (start_cnt[which] < target && guard < 20000) begin
      @(negedge clk);
      guard++;
    end
    if (start_cnt[which] < target) begin
      checks++; errors++;
      $display("FAIL frame_start dut%0d actual %0d required %0d", which, start_cnt[which], target);
    end
  endtask

  // Two words: the first into an idle empty block (latency), the second queued behind it (frame length)
  task automatic pair_test(input int which, input logic [63:0] d0, input int p,
                           input bit s2, input logic [1:0] pm);
    frame_t      f0, f1;
    logic [63:0] d1;
    longint      acc0, acc1, s0, s1;
    int          dw, base;
    dw = (which == 0) ? 8 : 64;
    base = done_cnt[which];
    if (which == 0) st8.delete(); else st64.delete();
    d1 = {$urandom, $urandom};
    if (dw == 8) d1 = {56'd0, d1[7:0]};
    prescale = p[15:0]; stop2 = s2; parity_mode = pm;
    f0 = make_frame(d0, dw, p, s2, pm);
    f1 = make_frame(d1, dw, p, s2, pm);
    push_exp(which, f0);
    push_exp(which, f1);
    send(which, d0, acc0);
    send(which, d1, acc1);
    wait_done(which, base + 2);
    if (start_count(which) >= 2) begin
      s0 = pop_start(which);
      s1 = pop_start(which);
      check("start_latency", (s0 - acc0) / 10, 2);
      check("frame_cycles", (s1 - s0) / 10, f0.nbits * f0.t);
    end else begin
      checks++; errors++;
      $display("FAIL start_records dut%0d actual %0d required 2", which, start_count(which));
    end
    $display("pair dut%0d words %h %h presc %0d stop2 %0d parity %0d frame %0d cycles",
             which, d0, d1, p, s2, pm, f0.nbits * f0.t);
  endtask

  initial begin
    frame_t      f;
    longint      acc, first_s, last_s;
    logic [63:0] w;
    int          fall_at, base;

    repeat (3) @(negedge clk);
    check("reset_txd", txd8, 1);
    check("reset_busy", busy8, 0);
    check("reset_tready", tready8, 0);
    check("reset_level", level8, 0);
    rst = 1'b0;
    #1 check("tready_before_edge", tready8, 0);
    @(posedge clk);
    #1 check("tready_after_edge", tready8, 1);
    @(negedge clk);

    pair_test(0, 64'hA5, 2, 1'b0, 2'b00);
    pair_test(0, 64'hA5, 2, 1'b0, 2'b01);
    pair_test(0, 64'hA5, 2, 1'b0, 2'b10);
    pair_test(0, 64'hA5, 2, 1'b1, 2'b01);
    pair_test(0, 64'h3C, 0, 1'b0, 2'b00);

    // prescale changed mid-frame: current frame keeps T=16, next word uses T=24
    st8.delete();
    prescale = 16'd2; stop2 = 1'b0; parity_mode = 2'b00;
    base = done_cnt[0];
    w = 64'($urandom_range(0, 255));
    push_exp(0, make_frame(w, 8, 2, 1'b0, 2'b00));
    send(0, w, acc);
    wait_start(0, start_cnt[0] + 1);
    prescale = 16'd3;
    f = make_frame(64'h5A, 8, 3, 1'b0, 2'b00);
    push_exp(0, f);
    send(0, 64'h5A, acc);
    wait_done(0, base + 2);
    if (st8.size() >= 2) check("presc_change_gap", (st8[1] - st8[0]) / 10, 160);
    else check("presc_change_starts", st8.size(), 2);
    $display("presc_change words %h 5a", w[7:0]);

    // tvalid held high with 8 words into the depth-4 FIFO
    st8.delete();
    prescale = 16'd0;
    base = done_cnt[0];
    peak8 = 0;
    fall_at = 0;
    for (int k = 0; k < 8; k++) begin
      w = 64'($urandom_range(0, 255));
      f = make_frame(w, 8, 0, 1'b0, 2'b00);
      push_exp(0, f);
      send(0, w, acc);
      tvalid8 = 1'b1;
      if (!tready8 && fall_at == 0) fall_at = k + 1;
      $display("fifo word %0d data %h accepted at %0t", k, w[7:0], acc);
    end
    tvalid8 = 1'b0;
    wait_done(0, base + 8);
    check("accepted_before_full", fall_at, 5);
    check("fifo_peak", peak8, 4);
    if (st8.size() >= 8) begin
      first_s = st8[0];
      last_s = st8[7];
      check("back_to_back_span", (last_s - first_s) / 10, 7 * f.nbits * f.t);
    end else check("fifo_starts", st8.size(), 8);

    // reset asserted mid-DATA with three words still queued
    st8.delete();
    prescale = 16'd1;
    base = start_cnt[0];
    push_exp(0, make_frame(64'h00, 8, 1, 1'b0, 2'b00));
    send(0, 64'h00, acc);
    for (int k = 0; k < 3; k++) begin
      w = 64'($urandom_range(0, 255));
      push_exp(0, make_frame(w, 8, 1, 1'b0, 2'b00));
      send(0, w, acc);
    end
    wait_start(0, base + 1);
    repeat (12) @(negedge clk);
    check("pre_reset_level", level8, 3);
    check("pre_reset_txd", txd8, 0);
    rst = 1'b1;
    #1;
    check("async_reset_txd", txd8, 1);
    check("async_reset_level", level8, 0);
    check("async_reset_busy", busy8, 0);
    check("async_reset_tready", tready8, 0);
    exp8.delete();
    st8.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("tready_held_after_reset", tready8, 0);
    @(posedge clk);
    #1 check("tready_raised_after_reset", tready8, 1);
    @(negedge clk);
    check("idle_after_reset_txd", txd8, 1);
    pair_test(0, 64'($urandom_range(0, 255)), 1, 1'b0, 2'b00);

    for (int k = 0; k < 8; k++) begin
      pair_test(0, 64'($urandom_range(0, 255)), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    end

    pair_test(1, 64'h8000_0000_0000_0001, 1, 1'b0, 2'b00);

    repeat (4) @(negedge clk);
    check("final_idle_txd8", txd8, 1);
    check("final_idle_busy8", busy8, 0);
    check("final_idle_txd64", txd64, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_framed.md
UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: data bits per frame, legal range 5..64.
REQ-002 SHALL have parameter FIFO_DEPTH, default 16: input FIFO entries, power of two, 2..256.
REQ-003 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port s_axis_tdata  input  DATA_WIDTH: word to transmit.
REQ-006 SHALL have port s_axis_tvalid  input  1: tdata valid.
REQ-007 SHALL have port s_axis_tready  output  1: FIFO can accept a word.
REQ-008 SHALL have port txd  output  1: serial line, idle high.
REQ-009 SHALL have port busy  output  1: frame in progress or FIFO non-empty.
REQ-010 SHALL have port fifo_level  output  $clog2(FIFO_DEPTH+1): words held in the FIFO.
REQ-011 SHALL have port prescale  input  16: bit period T = 8*prescale clk cycles; prescale 0 treated as 1.
REQ-012 SHALL have port stop2  input  1: 1 selects two stop bits, 0 selects one.
REQ-013 SHALL have port parity_mode  input  2: 00 none, 01 even, 10 odd, 11 none.

Function
REQ-014 SHALL accept a word on any rising edge where s_axis_tvalid and s_axis_tready are both high.
REQ-015 SHALL drive s_axis_tready as (fifo_level < FIFO_DEPTH), derived from registered state only, with no path from tvalid.
REQ-016 SHALL support a push and a pop on the same edge, leaving fifo_level unchanged.
REQ-017 SHALL have FSM states IDLE, START, DATA, PARITY, STOP.
REQ-018 SHALL, in IDLE with the FIFO non-empty, pop one word and enter START at the next edge.
REQ-019 SHALL latch prescale, stop2 and parity_mode at that pop; changes mid-frame SHALL NOT affect the current frame.
REQ-020 SHALL transmit the start bit (0) for T cycles, then DATA_WIDTH data bits LSB first for T cycles each.
REQ-021 SHALL then transmit a parity bit for T cycles when the latched mode is even or odd; otherwise skip PARITY.
REQ-022 SHALL make the parity bit the XOR of the data bits for even mode and its inverse for odd mode.
REQ-023 SHALL transmit the stop bit (1) for T cycles, or 2T when stop2 was latched high.
REQ-024 SHALL, at the end of STOP, pop the next word and enter START on the same edge when the FIFO is non-empty (no idle gap); otherwise enter IDLE.
REQ-025 SHALL make txd a registered output, so the first start-bit edge follows the accepting edge of an empty, idle block by exactly 2 cycles.
REQ-026 SHALL use a bit-period counter of at least 19 bits and a bit counter of at least 7 bits, with no overflow at prescale = 0xFFFF or DATA_WIDTH = 64.

Reset
REQ-027 SHALL, while rst is high, immediately force txd=1, busy=0, s_axis_tready=0, fifo_level=0, and the FSM to IDLE.
REQ-028 SHALL discard the FIFO contents and any partial frame on reset; no word is resumed.
REQ-029 SHALL raise s_axis_tready on the first rising edge after rst deasserts.

Configuration
REQ-030 SHALL compile parity support only when UART_TX_FRAMED_PARITY_EN is defined.
REQ-031 SHALL, without UART_TX_FRAMED_PARITY_EN, keep the parity_mode port, ignore it, omit the PARITY state logic, and send no parity bit.

Verification
REQ-032 SHALL cover: DATA_WIDTH=8, prescale=2 (T=16), no parity, 1 stop, send 0xA5 -> txd low 16 cycles, bits 1,0,1,0,0,1,0,1 (16 each), then high 16; frame 160 cycles.
REQ-033 SHALL cover: same setup with the macro defined, send 0xA5 -> even mode parity bit 0, odd mode parity bit 1; frame 176 cycles. Repeat with stop2=1 -> frame 192 cycles.
REQ-034 SHALL cover: FIFO_DEPTH=4, tvalid held high with 8 words -> 5 accepted before tready first falls, fifo_level peaks at 4, frames back-to-back with no idle cycles, all 8 words sent in order.
REQ-035 SHALL cover: rst asserted mid-DATA with 3 words queued -> txd=1 and fifo_level=0 without waiting for a clock edge; the next word sent after reset transmits cleanly.
REQ-036 SHALL cover: prescale=0 -> T=8 cycles; prescale changed mid-frame -> current frame keeps its original T and the next frame uses the new value.
REQ-037 SHALL cover: DATA_WIDTH=64, prescale=1, send 0x8000_0000_0000_0001 -> 66 bit periods (528 cycles), with the first and last data bits high.
